pipe_stage_elastic: RTL and testbench

//  Parametrised successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB stage registers.

---
 rtl/pipe_stage_elastic.sv | 144 ++++++++++++++
 tb/tb_pipe_stage_elastic.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: elastic valid/ready stage, main + skid entry, flush, bubble masking.
// Optional PIPE_STAGE_PERF_EN adds stall_cnt/bubble_cnt.
//
// Ports:
//   clk, rst (sync, active-low), flush        : clock / control
//   in_valid, in_ready, in_data, in_ctrl      : upstream side
//   out_valid, out_ready, out_data, out_ctrl  : downstream side
//   stall_cnt, bubble_cnt                     : perf counters (PIPE_STAGE_PERF_EN only)
module pipe_stage_elastic #(
  parameter int DATA_W     = 64,
  parameter int CTRL_W     = 8,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

  logic main_valid;
  logic push;
  logic pop;

  // in_ready comes straight from the state flop, so it never
  // depends combinationally on out_ready.
  assign main_valid = (state_q != EMPTY);
  assign in_ready   = (state_q != TWO);
  assign out_valid  = main_valid;
  assign push       = in_valid & in_ready;
  assign pop        = main_valid & out_ready;

  assign out_ctrl = main_valid ? main_ctrl_q : '0;
  assign out_data = (CLEAR_DATA && !main_valid) ? '0 : main_data_q;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            state_d     = ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end
        ONE: begin
          if (push && !pop) begin
            state_d     = TWO;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else if (push && pop) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_d     = ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            skid_data_d = '0;
            skid_ctrl_d = '0;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Flush does not clear the counters; only reset does.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (main_valid && !out_ready) stall_cnt_d = stall_cnt_q + 32'd1;
    if (!main_valid) bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: randomized bench for pipe_stage_elastic
// against a queue-based occupancy model.
module tb_pipe_stage_elastic;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  c;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic [7:0]  in_ctrl = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] bubble_cnt;
  logic [31:0] stall_m = '0;
  logic [31:0] bubble_m = '0;
`endif

  int vecs = 0;
  int errs = 0;

  ent_t mq[$];
  bit   m_rdy;
  bit   m_push;
  bit   m_pop;

  always #5 clk = ~clk;

  pipe_stage_elastic #(
    .DATA_W(64),
    .CTRL_W(8),
    .CLEAR_DATA(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_ctrl(in_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_ctrl(out_ctrl)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt(stall_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  // Reference: a FIFO of capacity 2 whose ready flag is the
  // occupancy seen before the edge.
  always @(posedge clk) begin
    m_rdy  = (mq.size() < 2);
    m_push = in_valid && m_rdy;
    m_pop  = (mq.size() > 0) && out_ready;
`ifdef PIPE_STAGE_PERF_EN
    if (!rst) begin
      stall_m  = '0;
      bubble_m = '0;
    end else begin
      if (mq.size() > 0 && !out_ready) stall_m = stall_m + 1;
      if (mq.size() == 0) bubble_m = bubble_m + 1;
    end
`endif
    if (!rst || flush) begin
      mq.delete();
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back('{in_data, in_ctrl});
    end
  end

  function automatic logic [73:0] exp_vec();
    ent_t h;
    h = '0;
    if (mq.size() != 0) h = mq[0];
    return {mq.size() != 0, mq.size() < 2, h.c, h.d};
  endfunction

  function automatic logic [73:0] dut_vec();
    return {out_valid, in_ready, out_ctrl, out_data};
  endfunction

  task automatic drv(input bit v, input logic [63:0] d,
                     input logic [7:0] c, input bit ordy,
                     input bit fl);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drv(1'b1, 64'hDEAD, 8'hFF, 1'b1, 1'b0);
    drv(1'b1, 64'hBEEF, 8'hFF, 1'b1, 1'b0);
    vecs++;
    if (dut_vec() !== {1'b0, 1'b1, 8'h00, 64'h0}) begin
      errs++;
      $display("FAIL reset: got %h required %h", dut_vec(),
               {1'b0, 1'b1, 8'h00, 64'h0});
    end
    rst = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic test_stream();
    logic [63:0] exp_s[3];
    exp_s = '{64'h11, 64'h22, 64'h33};
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, exp_s[i], 8'h0F, 1'b1, 1'b0);
      vecs++;
      if (!out_valid || !in_ready || out_data !== exp_s[i]) begin
        errs++;
        $display("FAIL stream[%0d]: got v=%b r=%b d=%h required v=1 r=1 d=%h",
                 i, out_valid, in_ready, out_data, exp_s[i]);
      end
      vecs++;
      if (dut_vec() !== exp_vec()) begin
        errs++;
        $display("FAIL stream_model[%0d]: got %h required %h",
                 i, dut_vec(), exp_vec());
      end
    end
    drv(1'b0, 64'h0, 8'h0, 1'b1, 1'b0);
    vecs++;
    if (out_valid !== 1'b0) begin
      errs++;
      $display("FAIL stream_drain: got v=%b required v=0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] got[$];
    bit          c_sent;
    bit          cv;
    c_sent = 1'b0;
    drv(1'b1, 64'h1, 8'h01, 1'b0, 1'b0);
    drv(1'b1, 64'h2, 8'h02, 1'b0, 1'b0);
    vecs++;
    if (in_ready !== 1'b0) begin
      errs++;
      $display("FAIL bp_full: got in_ready=%b required 0", in_ready);
    end
    for (int k = 0; k < 2; k++) begin
      drv(1'b1, 64'h3, 8'h03, 1'b0, 1'b0);
      vecs++;
      if (in_ready !== 1'b0 || out_data !== 64'h1) begin
        errs++;
        $display("FAIL bp_hold[%0d]: got r=%b d=%h required r=0 d=1",
                 k, in_ready, out_data);
      end
    end
    for (int k = 0; k < 6; k++) begin
      if (out_valid) got.push_back(out_data);
      cv = !c_sent;
      if (cv && in_ready) c_sent = 1'b1;
      drv(cv, 64'h3, 8'h03, 1'b1, 1'b0);
      vecs++;
      if (dut_vec() !== exp_vec()) begin
        errs++;
        $display("FAIL bp_model[%0d]: got %h required %h",
                 k, dut_vec(), exp_vec());
      end
    end
    vecs++;
    if (got.size() != 3 || got[0] !== 64'h1 || got[1] !== 64'h2 ||
        got[2] !== 64'h3) begin
      errs++;
      $display("FAIL bp_order: got %p required 1,2,3", got);
    end
  endtask

  task automatic test_flush();
    drv(1'b1, 64'hA1, 8'h5A, 1'b0, 1'b0);
    drv(1'b1, 64'hA2, 8'h5A, 1'b0, 1'b0);
    drv(1'b1, 64'hA3, 8'h5A, 1'b0, 1'b1);
    vecs++;
    if (dut_vec() !== {1'b0, 1'b1, 8'h00, 64'h0}) begin
      errs++;
      $display("FAIL flush_two: got %h required %h", dut_vec(),
               {1'b0, 1'b1, 8'h00, 64'h0});
    end
    drv(1'b1, 64'hB1, 8'h5A, 1'b0, 1'b0);
    drv(1'b1, 64'hB2, 8'h5A, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      vecs++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errs++;
        $display("FAIL flush_one[%0d]: got v=%b r=%b required v=0 r=1",
                 k, out_valid, in_ready);
      end
      drv(1'b0, 64'h0, 8'h0, 1'b1, 1'b0);
    end
    vecs++;
    if (dut_vec() !== exp_vec()) begin
      errs++;
      $display("FAIL flush_model: got %h required %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_bubble();
    for (int k = 0; k < 40; k++) begin
      drv(1'($urandom % 2), {$urandom, $urandom}, 8'hFF, 1'b1, 1'b0);
      vecs++;
      if (!out_valid && (out_ctrl !== 8'h00 || out_data !== 64'h0)) begin
        errs++;
        $display("FAIL bubble[%0d]: got c=%h d=%h required c=00 d=0",
                 k, out_ctrl, out_data);
      end
      vecs++;
      if (dut_vec() !== exp_vec()) begin
        errs++;
        $display("FAIL bubble_model[%0d]: got %h required %h",
                 k, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom % 64) != 0;
      drv(1'($urandom % 3 != 0), {$urandom, $urandom}, 8'($urandom),
          1'($urandom % 2), 1'($urandom % 16 == 0));
      vecs++;
      if (dut_vec() !== exp_vec()) begin
        errs++;
        $display("FAIL random[%0d]: got %h required %h",
                 k, dut_vec(), exp_vec());
      end
`ifdef PIPE_STAGE_PERF_EN
      vecs++;
      if (stall_cnt !== stall_m || bubble_cnt !== bubble_m) begin
        errs++;
        $display("FAIL random_perf[%0d]: got s=%0d b=%0d required s=%0d b=%0d",
                 k, stall_cnt, bubble_cnt, stall_m, bubble_m);
      end
`endif
    end
    rst = 1'b1;
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    rst = 1'b0;
    drv(1'b0, 64'h0, 8'h0, 1'b0, 1'b0);
    rst = 1'b1;
    drv(1'b1, 64'h77, 8'h07, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) drv(1'b0, 64'h0, 8'h0, 1'b0, 1'b0);
    vecs++;
    if (stall_cnt !== 32'd5) begin
      errs++;
      $display("FAIL perf_stall: got %0d required 5", stall_cnt);
    end
    drv(1'b0, 64'h0, 8'h0, 1'b0, 1'b1);
    vecs++;
    if (stall_cnt !== 32'd6 || bubble_cnt !== 32'd1) begin
      errs++;
      $display("FAIL perf_flush: got s=%0d b=%0d required s=6 b=1",
               stall_cnt, bubble_cnt);
    end
    force dut.bubble_cnt_q = 32'hFFFF_FFFF;
    bubble_m = 32'hFFFF_FFFF;
    #1;
    release dut.bubble_cnt_q;
    drv(1'b0, 64'h0, 8'h0, 1'b1, 1'b0);
    vecs++;
    if (bubble_cnt !== 32'd0) begin
      errs++;
      $display("FAIL perf_wrap: got %h required 0", bubble_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_bubble();
    test_random();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
